serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Parametrised, multi-cycle successor to the single-bit half subtractor.
- Computes an N-bit difference, A - B - Bin, bit-serially, LSB first, one bit per clock.
- Uses one registered borrow, so each cycle behaves as a full-subtractor stage.
- Serves as an area-lean arithmetic unit with a start/busy/done handshake for control-path use.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_a  input  WIDTH  minuend; latched when start is accepted.
- i_b  input  WIDTH  subtrahend; latched when start is accepted.
- i_bin  input  1  borrow-in; latched when start is accepted.
- o_busy  output  1  high whenever state != IDLE.
- o_done  output  1  one-cycle pulse; o_diff and o_bout are valid in this cycle.
- o_diff  output  WIDTH  registered difference; held until the next completion.
- o_bout  output  1  registered final borrow-out; held until the next completion.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset: state=IDLE, bit counter=0, internal shift registers=0, borrow=0. o_busy=0, o_done=0, o_diff=0, o_bout=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if i_start=1 at edge k:
  - latch i_a and i_b into shift registers;
  - load borrow register with i_bin;
  - clear counter; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: at each edge, process bit 0 of the operand shift registers:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - shift d into the MSB of the result shift register; shift both operand registers right by one; counter += 1.
  - When counter == WIDTH-1 at an edge: that edge processes the last bit, loads o_diff from the completed result, loads o_bout from br_next, and moves to DONE.
- DONE: o_done=1 for exactly this one cycle; the next edge returns to IDLE.
- Timing: start sampled at edge k gives o_done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles of o_busy.
- Next operation: the earliest next accepted start is at the edge after returning to IDLE, giving a throughput of one operation per WIDTH+2 cycles.
- i_start while o_busy=1 (SHIFT or DONE): ignored, with no queuing. Operand inputs may change freely after acceptance.
- Arithmetic: result is modulo 2^WIDTH. o_bout=1 iff A < B + Bin, treating A and B as unsigned.
- Reset mid-operation: aborts immediately with no o_done pulse. o_diff and o_bout are cleared to 0.
- Counter width: $clog2(WIDTH); it must not wrap before WIDTH-1 is reached.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined: when the final borrow is 1, o_diff is loaded with 0 (unsigned saturation at zero). o_bout still reports 1.
- Undefined: o_diff wraps modulo 2^WIDTH. No extra logic is generated.

Test Plan:
- WIDTH=8, A=200, B=55, Bin=0, start at edge k -> o_done in cycle after edge k+8; o_diff=145, o_bout=0; o_busy high for 9 cycles.
- A=5, B=10, Bin=0 -> o_diff=251, o_bout=1. With SERIAL_SUB_SAT_EN defined: o_diff=0, o_bout=1.
- A=0, B=0, Bin=1 -> o_diff=255, o_bout=1. Also A=255, B=255, Bin=0 -> o_diff=0, o_bout=0.
- Start with A=9, B=3, then i_start=1 on every cycle, with A=1 and B=2 applied from the cycle after acceptance -> exactly one o_done, result 6; the second op is accepted only after return to IDLE and yields 255, bout=1.
- Assert i_rst for one cycle at the 4th SHIFT edge of A=100, B=1 -> no o_done; o_busy=0, o_diff=0 after reset. A new start of 100-1 completes normally with 99.
- Random sweep, WIDTH=4 and WIDTH=16, 1000 ops -> o_diff and o_bout match the reference model (A-B-Bin) mod 2^WIDTH and the borrow; every o_done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_bin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_bout;

  modport master (
    output i_start, i_a, i_b, i_bin,
    input  o_busy, o_done, o_diff, o_bout
  );

  modport slave (
    input  i_start, i_a, i_b, i_bin,
    output o_busy, o_done, o_diff, o_bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock, start/busy/done handshake.
// Optional macro SERIAL_SUB_SAT_EN: saturate o_diff to zero when the final borrow is set.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             bit_d;
  logic             br_nx;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  // Full-subtractor stage on the current LSBs; result fills from the MSB end.
  always_comb begin
    bit_d     = a_q[0] ^ b_q[0] ^ br_q;
    br_nx     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_shift = {bit_d, res_q[WIDTH-1:1]};
    last_bit  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    diff_d = diff_q;
    br_d   = br_q;
    bout_d = bout_q;
    if (state_q == IDLE && bus.i_start) begin
      a_d   = bus.i_a;
      b_d   = bus.i_b;
      br_d  = bus.i_bin;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_nx;
      res_d = res_shift;
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
`ifdef SERIAL_SUB_SAT_EN
        diff_d = br_nx ? '0 : res_shift;
`else
        diff_d = res_shift;
`endif
        bout_d = br_nx;
      end
    end
  end

  always_comb begin
    bus.o_busy = (state_q != IDLE);
    bus.o_done = (state_q == DONE);
  end

  assign bus.o_diff = diff_q;
  assign bus.o_bout = bout_q;
endmodule
